// File: rtl/board_tile_renderer.sv
// Tile renderer for stacked Battleship boards with double-buffered per-cell state.
// Optional cursor highlight and blink enabled by defining BOARD_TILE_RENDERER_CURSOR_EN.
module board_tile_renderer #(
    parameter int unsigned NUM_BOARDS     = 2,
    parameter int unsigned GRID_N         = 10,
    parameter int unsigned CELL_PITCH     = 16,
    parameter int unsigned BOARD_OFFSET_X = 234,
    parameter int unsigned BOARD_OFFSET_Y = 67,
    parameter int unsigned BOARD_GAP_Y    = 0,
    parameter int unsigned BLINK_FRAMES   = 15
) (
    input  logic       vga_clk,
    input  logic       rst,
    input  logic [9:0] next_x,
    input  logic [9:0] next_y,
    input  logic       wr_en,
    input  logic [1:0] wr_board,
    input  logic [3:0] wr_row,
    input  logic [3:0] wr_col,
    input  logic [1:0] wr_state,
    input  logic       clr_en,
    input  logic [1:0] clr_board,
    input  logic       cursor_on,
    input  logic [1:0] cursor_board,
    input  logic [3:0] cursor_row,
    input  logic [3:0] cursor_col,
    output logic [7:0] r_in,
    output logic [7:0] g_in,
    output logic [7:0] b_in,
    output logic       frame_start,
    output logic       wr_err
);

    localparam int unsigned BOARD_PX     = GRID_N * CELL_PITCH + 1;
    localparam int unsigned BOARD_STRIDE = BOARD_PX + BOARD_GAP_Y;
    localparam int unsigned PITCH_SH     = $clog2(CELL_PITCH);
    localparam int unsigned BOARD_CELLS  = GRID_N * GRID_N;
    localparam int unsigned CELLS        = NUM_BOARDS * BOARD_CELLS;
    localparam int unsigned IW           = $clog2(CELLS);

    logic [1:0]    shadow_q [CELLS];
    logic [1:0]    shadow_d [CELLS];
    logic [1:0]    live_q   [CELLS];
    logic          commit;
    logic          wr_ok;
    logic          clr_ok;
    logic [IW-1:0] wr_idx;

    assign commit = (next_x == 10'd0) && (next_y == 10'd0);
    assign wr_ok  = ({1'b0, wr_board} < 3'(NUM_BOARDS)) && ({1'b0, wr_row} < 5'(GRID_N)) &&
                    ({1'b0, wr_col} < 5'(GRID_N));
    assign clr_ok = clr_en && ({1'b0, clr_board} < 3'(NUM_BOARDS));
    assign wr_idx = IW'((32'(wr_board) * GRID_N + 32'(wr_row)) * GRID_N + 32'(wr_col));

    // Clear is applied after the write so it wins on the same board.
    always_comb begin
        for (int i = 0; i < CELLS; i++) begin
            shadow_d[i] = shadow_q[i];
            if (wr_en && wr_ok && (wr_idx == IW'(i))) shadow_d[i] = wr_state;
            if (clr_ok && (clr_board == 2'(i / BOARD_CELLS))) shadow_d[i] = 2'd0;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            for (int i = 0; i < CELLS; i++) begin
                shadow_q[i] <= 2'd0;
                live_q[i]   <= 2'd0;
            end
        end else begin
            shadow_q <= shadow_d;
            if (commit) live_q <= shadow_d;
        end
    end

`ifdef BOARD_TILE_RENDERER_CURSOR_EN
    localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

    logic          cur_on_q;
    logic [1:0]    cur_board_q;
    logic [3:0]    cur_row_q;
    logic [3:0]    cur_col_q;
    logic          blink_on_q;
    logic [BW-1:0] blink_cnt_q;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            cur_on_q    <= 1'b0;
            cur_board_q <= 2'd0;
            cur_row_q   <= 4'd0;
            cur_col_q   <= 4'd0;
            blink_on_q  <= 1'b1;
            blink_cnt_q <= '0;
        end else if (commit) begin
            cur_on_q    <= cursor_on;
            cur_board_q <= cursor_board;
            cur_row_q   <= cursor_row;
            cur_col_q   <= cursor_col;
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_q <= '0;
                blink_on_q  <= ~blink_on_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end
`else
    logic cursor_unused;
    assign cursor_unused = ^{cursor_on, cursor_board, cursor_row, cursor_col, 1'(BLINK_FRAMES)};
`endif

    int unsigned   lx;
    int unsigned   ly;
    int unsigned   bsel;
    int unsigned   cell_row;
    int unsigned   cell_col;
    logic          in_board;
    logic          on_line;
    logic [IW-1:0] pix_idx;
    logic [7:0]    colour;
    logic [23:0]   rgb_d;

    always_comb begin
        in_board = 1'b0;
        bsel     = 0;
        ly       = 0;
        lx       = 32'(next_x) - BOARD_OFFSET_X;
        if ((32'(next_x) >= BOARD_OFFSET_X) && (32'(next_x) < BOARD_OFFSET_X + BOARD_PX)) begin
            for (int b = 0; b < NUM_BOARDS; b++) begin
                if ((32'(next_y) >= BOARD_OFFSET_Y + b * BOARD_STRIDE) &&
                    (32'(next_y) < BOARD_OFFSET_Y + b * BOARD_STRIDE + BOARD_PX)) begin
                    in_board = 1'b1;
                    bsel     = b;
                    ly       = 32'(next_y) - (BOARD_OFFSET_Y + b * BOARD_STRIDE);
                end
            end
        end
        cell_row = ly >> PITCH_SH;
        cell_col = lx >> PITCH_SH;
        on_line  = ((lx & (CELL_PITCH - 1)) == 0) || ((ly & (CELL_PITCH - 1)) == 0);
        pix_idx  = IW'((bsel * GRID_N + cell_row) * GRID_N + cell_col);
        case (live_q[pix_idx])
            2'd0:    colour = 8'h03;
            2'd1:    colour = 8'h92;
            2'd2:    colour = 8'hFF;
            default: colour = 8'hE0;
        endcase
        if (on_line) colour = 8'h00;
`ifdef BOARD_TILE_RENDERER_CURSOR_EN
        if (!on_line && cur_on_q && blink_on_q && (bsel == 32'(cur_board_q)) &&
            (cell_row == 32'(cur_row_q)) && (cell_col == 32'(cur_col_q))) colour = 8'hFC;
`endif
        if (!in_board) rgb_d = 24'hFFFFFF;
        else           rgb_d = {colour[7:5], 5'b0, colour[4:2], 5'b0, colour[1:0], 6'b0};
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_in        <= 8'h00;
            g_in        <= 8'h00;
            b_in        <= 8'h00;
            frame_start <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            {r_in, g_in, b_in} <= rgb_d;
            frame_start        <= commit;
            wr_err             <= wr_en && !wr_ok;
        end
    end

endmodule

// File: tb/tb_board_tile_renderer.sv
// Bench for board_tile_renderer: directed scenarios plus random traffic against a board model.
module tb_board_tile_renderer;

    localparam int NB  = 2;
    localparam int GN  = 10;
    localparam int P   = 16;
    localparam int OX  = 234;
    localparam int OY  = 67;
    localparam int GAP = 0;
    localparam int BF  = 15;
    localparam int BPX = GN * P + 1;

    logic       vga_clk;
    logic       rst;
    logic [9:0] next_x, next_y;
    logic       wr_en;
    logic [1:0] wr_board;
    logic [3:0] wr_row, wr_col;
    logic [1:0] wr_state;
    logic       clr_en;
    logic [1:0] clr_board;
    logic       cursor_on;
    logic [1:0] cursor_board;
    logic [3:0] cursor_row, cursor_col;
    logic [7:0] r_in, g_in, b_in;
    logic       frame_start, wr_err;

    board_tile_renderer #(
        .NUM_BOARDS(NB), .GRID_N(GN), .CELL_PITCH(P), .BOARD_OFFSET_X(OX),
        .BOARD_OFFSET_Y(OY), .BOARD_GAP_Y(GAP), .BLINK_FRAMES(BF)
    ) dut (
        .vga_clk(vga_clk), .rst(rst), .next_x(next_x), .next_y(next_y),
        .wr_en(wr_en), .wr_board(wr_board), .wr_row(wr_row), .wr_col(wr_col),
        .wr_state(wr_state), .clr_en(clr_en), .clr_board(clr_board),
        .cursor_on(cursor_on), .cursor_board(cursor_board), .cursor_row(cursor_row),
        .cursor_col(cursor_col), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .frame_start(frame_start), .wr_err(wr_err)
    );

    initial vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int shadow_m [4][16][16];
    int live_m   [4][16][16];
    bit cur_on_m;
    int cur_b_m, cur_r_m, cur_c_m;
    int frames_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] state_colour(input int st);
        case (st)
            0:       return 8'h03;
            1:       return 8'h92;
            2:       return 8'hFF;
            default: return 8'hE0;
        endcase
    endfunction

    function automatic logic [23:0] model_pixel(input int x, input int y);
        logic [7:0] c;
        for (int b = 0; b < NB; b++) begin
            int y0 = OY + b * (BPX + GAP);
            if (x >= OX && x < OX + BPX && y >= y0 && y < y0 + BPX) begin
                int lx = x - OX;
                int ly = y - y0;
                if (lx % P == 0 || ly % P == 0) c = 8'h00;
                else begin
                    c = state_colour(live_m[b][ly / P][lx / P]);
`ifdef BOARD_TILE_RENDERER_CURSOR_EN
                    if (cur_on_m && ((frames_m / BF) % 2 == 0) && b == cur_b_m &&
                        ly / P == cur_r_m && lx / P == cur_c_m) c = 8'hFC;
`endif
                end
                return {c[7:5], 5'b0, c[4:2], 5'b0, c[1:0], 6'b0};
            end
        end
        return 24'hFFFFFF;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 4; b++)
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++) begin
                    shadow_m[b][r][c] = 0;
                    live_m[b][r][c]   = 0;
                end
        cur_on_m = 0; cur_b_m = 0; cur_r_m = 0; cur_c_m = 0; frames_m = 0;
    endtask

    // One pixel clock: predict, clock, compare, then advance the model.
    task automatic cycle(input int x, input int y);
        logic [23:0] e_rgb;
        logic        e_fs, e_err;
        bit          wv, cv;
        next_x = 10'(x);
        next_y = 10'(y);
        wv     = wr_en && wr_board < NB && wr_row < GN && wr_col < GN;
        cv     = clr_en && clr_board < NB;
        e_rgb  = rst ? 24'h0 : model_pixel(x, y);
        e_fs   = !rst && x == 0 && y == 0;
        e_err  = !rst && wr_en && !wv;
        @(posedge vga_clk);
        #1;
        chk($sformatf("rgb(%0d,%0d)", x, y), 32'({r_in, g_in, b_in}), 32'(e_rgb));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("wr_err", 32'(wr_err), 32'(e_err));
        if (rst) model_reset();
        else begin
            if (wv) shadow_m[wr_board][wr_row][wr_col] = wr_state;
            if (cv)
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 16; c++) shadow_m[clr_board][r][c] = 0;
            if (x == 0 && y == 0) begin
                live_m   = shadow_m;
                cur_on_m = cursor_on;
                cur_b_m  = cursor_board;
                cur_r_m  = cursor_row;
                cur_c_m  = cursor_col;
                frames_m++;
            end
        end
        wr_en  = 1'b0;
        clr_en = 1'b0;
    endtask

    task automatic do_write(input int b, input int r, input int c, input int s);
        wr_en = 1'b1; wr_board = 2'(b); wr_row = 4'(r); wr_col = 4'(c); wr_state = 2'(s);
    endtask

    task automatic do_clear(input int b);
        clr_en = 1'b1; clr_board = 2'(b);
    endtask

    initial begin
        int x, y;
        rst = 1'b1; next_x = '0; next_y = '0;
        wr_en = 0; wr_board = 0; wr_row = 0; wr_col = 0; wr_state = 0;
        clr_en = 0; clr_board = 0;
        cursor_on = 0; cursor_board = 0; cursor_row = 0; cursor_col = 0;
        model_reset();

        // Reset state
        cycle(100, 100);
        chk("reset_rgb", 32'({r_in, g_in, b_in}), 32'h0);
        cycle(242, 75);
        rst = 1'b0;

        // Default picture after one frame
        cycle(0, 0);
        cycle(242, 75);
        chk("t1_water", 32'({r_in, g_in, b_in}), 32'h0000C0);
        cycle(234, 75);
        chk("t1_line", 32'({r_in, g_in, b_in}), 32'h000000);
        cycle(100, 100);
        chk("t1_outside", 32'({r_in, g_in, b_in}), 32'hFFFFFF);

        // Mid-frame write only shows after commit
        do_write(0, 3, 4, 3);
        cycle(300, 123);
        cycle(300, 123);
        chk("t2_before", 32'({r_in, g_in, b_in}), 32'h0000C0);
        cycle(0, 0);
        cycle(300, 123);
        chk("t2_after", 32'({r_in, g_in, b_in}), 32'hE00000);

        // Out-of-range write
        do_write(0, 10, 0, 1);
        cycle(300, 123);
        chk("t3_err", 32'(wr_err), 32'h1);
        do_write(3, 0, 0, 1);
        cycle(300, 123);
        do_write(0, 0, 12, 2);
        cycle(300, 123);
        cycle(300, 123);
        chk("t3_err_pulse", 32'(wr_err), 32'h0);
        cycle(0, 0);
        cycle(242, 236);
        chk("t3_no_alias", 32'({r_in, g_in, b_in}), 32'h0000C0);

        // Clear beats same-cycle write to the same board; other board's write proceeds
        do_write(0, 6, 6, 1);
        cycle(10, 10);
        do_write(1, 0, 0, 1);
        do_clear(1);
        cycle(10, 10);
        do_write(0, 5, 5, 2);
        do_clear(1);
        cycle(10, 10);
        do_clear(3);
        cycle(10, 10);
        cycle(0, 0);
        cycle(242, 236);
        chk("t4_cleared", 32'({r_in, g_in, b_in}), 32'h0000C0);
        cycle(322, 155);
        chk("t4_other_board", 32'({r_in, g_in, b_in}), 32'hE0E0C0);

        // Write on the commit cycle is in that frame
        do_write(0, 1, 1, 3);
        cycle(0, 0);
        cycle(258, 91);
        chk("t5_same_frame", 32'({r_in, g_in, b_in}), 32'hE00000);

        // Cursor over a ship cell across many frames
        do_write(0, 2, 2, 1);
        cycle(10, 10);
        cursor_on = 1; cursor_board = 0; cursor_row = 2; cursor_col = 2;
        for (int f = 0; f < 40; f++) begin
            cycle(0, 0);
            cycle(274, 107);
`ifndef BOARD_TILE_RENDERER_CURSOR_EN
            chk("t6_no_cursor", 32'({r_in, g_in, b_in}), 32'h808080);
`endif
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                do_write($urandom_range(0, 3), $urandom_range(0, 11), $urandom_range(0, 11),
                         $urandom_range(0, 3));
            if ($urandom_range(0, 40) == 0) do_clear($urandom_range(0, 3));
            if ($urandom_range(0, 100) == 0) begin
                cursor_on    = 1'($urandom_range(0, 1));
                cursor_board = 2'($urandom_range(0, 3));
                cursor_row   = 4'($urandom_range(0, 11));
                cursor_col   = 4'($urandom_range(0, 11));
            end
            if ($urandom_range(0, 63) == 0) begin
                x = 0; y = 0;
            end else begin
                x = ($urandom_range(0, 9) < 8) ? $urandom_range(OX - 2, OX + BPX + 1)
                                               : $urandom_range(0, 639);
                y = ($urandom_range(0, 9) < 8) ? $urandom_range(OY - 2, OY + NB * BPX + 1)
                                               : $urandom_range(0, 479);
            end
            cycle(x, y);
        end

        // Mid-frame reset
        cycle(0, 0);
        rst = 1'b1;
        cycle(300, 123);
        chk("t8_rst_out", 32'({r_in, g_in, b_in}), 32'h0);
        rst = 1'b0;
        cycle(300, 123);
        chk("t8_first_pix", 32'({r_in, g_in, b_in}), 32'h0000C0);
        cycle(0, 0);
        cycle(258, 91);
        chk("t8_cleared", 32'({r_in, g_in, b_in}), 32'h0000C0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
